// File: rtl/alu4b_seq_ctrl_pkg.sv
// Shared constants, FSM state type and reference ALU function for alu4b_seq_ctrl.
package alu4b_seq_ctrl_pkg;
    localparam int DW = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic KIND_LOAD = 1'b0;
    localparam logic KIND_ALU  = 1'b1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Returns {carry, result}; subtraction carry is the inverted borrow.
    function automatic logic [DW:0] alu_model(input logic [1:0] s,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW:0] res;
        case (s)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
            OP_AND:  res = {1'b0, a & b};
            default: res = {1'b0, a | b};
        endcase
        return res;
    endfunction
endpackage

// File: rtl/alu4b_seq_ctrl_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port.
module alu4b_regfile
    import alu4b_seq_ctrl_pkg::*;
#(
    parameter int NREG   = 4,
    parameter int RIDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [RIDX_W-1:0] i_raddr_a,
    output logic [DW-1:0]     o_rdata_a,
    input  logic [RIDX_W-1:0] i_raddr_b,
    output logic [DW-1:0]     o_rdata_b
);
    logic [DW-1:0] r_mem [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_mem[gi] <= '0;
                else if (i_we && i_waddr == RIDX_W'(gi))
                    r_mem[gi] <= i_wdata;
            end
        end
    endgenerate

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/alu4b_seq_ctrl.sv
// Command sequencer around an external 4-bit ALU with result capture and response handshake.
// Optional ALU_SELF_CHECK_EN builds a reference model that sets sticky chk_err on mismatch.
module alu4b_seq_ctrl
    import alu4b_seq_ctrl_pkg::*;
#(
    parameter int NREG   = 4,
    parameter int RIDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_kind,
    input  logic [1:0]        cmd_op,
    input  logic [RIDX_W-1:0] cmd_rd,
    input  logic [RIDX_W-1:0] cmd_ra,
    input  logic [RIDX_W-1:0] cmd_rb,
    input  logic [DW-1:0]     cmd_imm,
    output logic [1:0]        alu_s,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    input  logic [DW-1:0]     alu_c,
    input  logic              alu_co,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_co,
    output logic              rsp_zero,
    output logic              chk_err
);
    state_t            r_state;
    logic [1:0]        r_alu_s;
    logic [DW-1:0]     r_alu_a;
    logic [DW-1:0]     r_alu_b;
    logic [RIDX_W-1:0] r_rd;
    logic [DW-1:0]     r_rsp_data;
    logic              r_rsp_co;
    logic              r_rsp_zero;

    logic              w_accept;
    logic              w_we;
    logic [RIDX_W-1:0] w_waddr;
    logic [DW-1:0]     w_wdata;
    logic [DW-1:0]     w_rdata_a;
    logic [DW-1:0]     w_rdata_b;

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = cmd_rd;
        w_wdata = cmd_imm;
        if (r_state == EXEC) begin
            w_we    = 1'b1;
            w_waddr = r_rd;
            w_wdata = alu_c;
        end else if (w_accept && cmd_kind == KIND_LOAD) begin
            w_we    = 1'b1;
        end
    end

    alu4b_regfile #(.NREG(NREG), .RIDX_W(RIDX_W)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (cmd_ra),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (cmd_rb),
        .o_rdata_b (w_rdata_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_alu_s    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rd       <= '0;
            r_rsp_data <= '0;
            r_rsp_co   <= 1'b0;
            r_rsp_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (cmd_kind == KIND_LOAD) begin
                            r_rsp_data <= cmd_imm;
                            r_rsp_co   <= 1'b0;
                            r_rsp_zero <= (cmd_imm == '0);
                            r_state    <= RESP;
                        end else begin
                            r_alu_a <= w_rdata_a;
                            r_alu_b <= w_rdata_b;
                            r_alu_s <= cmd_op;
                            r_rd    <= cmd_rd;
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_rsp_data <= alu_c;
                    r_rsp_co   <= alu_co;
                    r_rsp_zero <= (alu_c == '0);
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_s     = r_alu_s;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_co    = r_rsp_co;
    assign rsp_zero  = r_rsp_zero;

`ifdef ALU_SELF_CHECK_EN
    logic          r_chk_err;
    logic [DW:0]   w_model;

    assign w_model = alu_model(r_alu_s, r_alu_a, r_alu_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chk_err <= 1'b0;
        else if (r_state == EXEC && w_model != {alu_co, alu_c})
            r_chk_err <= 1'b1;
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif
endmodule
